control_unit_fsm: RTL and testbench

//   Multi-cycle control unit for the 64-bit RISC-V datapath (fd). Sequences each instruction

---
 rtl/control_unit_fsm_if.sv | 32 +++
 rtl/control_unit_fsm.sv | 137 +++++++++++++
 tb/tb_control_unit_fsm.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/control_unit_fsm_if.sv
// Control bundle between the multi-cycle control unit and the 64-bit RISC-V datapath.
// The control unit is the master and the datapath side is the slave.
interface control_unit_fsm_if #(
    parameter int unsigned CNT_WIDTH = 32
);
    logic                 run;
    logic [6:0]           opcode;
    logic [3:0]           alu_flags;
    logic                 d_mem_ready;
    logic                 d_mem_we;
    logic                 rf_we;
    logic [3:0]           alu_cmd;
    logic                 alu_src;
    logic                 pc_src;
    logic                 rf_src;
    logic                 pc_en;
    logic                 illegal_instr;
    logic [2:0]           state_dbg;
    logic [CNT_WIDTH-1:0] instret;

    modport master (
        input  run, opcode, alu_flags, d_mem_ready,
        output d_mem_we, rf_we, alu_cmd, alu_src, pc_src, rf_src, pc_en,
               illegal_instr, state_dbg, instret
    );

    modport slave (
        output run, opcode, alu_flags, d_mem_ready,
        input  d_mem_we, rf_we, alu_cmd, alu_src, pc_src, rf_src, pc_en,
               illegal_instr, state_dbg, instret
    );
endinterface

// File: rtl/control_unit_fsm.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer for the RISC-V datapath.
// Drives per-state control strobes, counts retired instructions and traps on errors.
module control_unit_fsm #(
    parameter int unsigned CNT_WIDTH   = 32,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    control_unit_fsm_if.master bus
);
    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        DECODE    = 3'd1,
        EXECUTE   = 3'd2,
        MEMORY    = 3'd3,
        WRITEBACK = 3'd4,
        ERROR     = 3'd7
    } state_t;

    state_t               state_q, state_d;
    logic [6:0]           op_q, op_d;
    logic [WAIT_W-1:0]    wait_q, wait_d;
    logic [CNT_WIDTH-1:0] instret_q;

    logic is_r, is_i, is_ld, is_st, is_br, legal_in;
    logic pc_en;

    logic unused_flags;
    assign unused_flags = ^bus.alu_flags;

    assign is_r     = (op_q == OP_R);
    assign is_i     = (op_q == OP_I);
    assign is_ld    = (op_q == OP_LD);
    assign is_st    = (op_q == OP_ST);
    assign is_br    = (op_q == OP_BR);
    assign legal_in = (bus.opcode == OP_R)  || (bus.opcode == OP_I) ||
                      (bus.opcode == OP_LD) || (bus.opcode == OP_ST) ||
                      (bus.opcode == OP_BR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            op_q      <= '0;
            wait_q    <= '0;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            wait_q  <= wait_d;
            if (pc_en) instret_q <= instret_q + 1'b1;
        end
    end

    always_comb begin
        state_d           = state_q;
        op_d              = op_q;
        wait_d            = wait_q;
        pc_en             = 1'b0;
        bus.d_mem_we      = 1'b0;
        bus.rf_we         = 1'b0;
        bus.alu_cmd       = '0;
        bus.alu_src       = 1'b0;
        bus.pc_src        = 1'b0;
        bus.rf_src        = 1'b0;
        bus.illegal_instr = 1'b0;

        // ALU controls depend only on op_q, so they stay fixed from EXECUTE to WRITEBACK.
        if (state_q == EXECUTE || state_q == MEMORY || state_q == WRITEBACK) begin
            bus.alu_cmd = (is_ld || is_st) ? 4'h0 : (is_br ? 4'h1 : 4'h2);
            bus.alu_src = is_i || is_ld || is_st;
        end

        case (state_q)
            FETCH: begin
                if (bus.run) state_d = DECODE;
            end
            DECODE: begin
                op_d    = bus.opcode;
                state_d = legal_in ? EXECUTE : ERROR;
            end
            EXECUTE: begin
                if (is_r || is_i) begin
                    state_d = WRITEBACK;
                end else if (is_ld || is_st) begin
                    state_d = MEMORY;
                    wait_d  = '0;
                end else if (is_br) begin
                    bus.pc_src = 1'b1;
                    pc_en      = 1'b1;
                    state_d    = FETCH;
                end else begin
                    state_d = ERROR;
                end
            end
            MEMORY: begin
                bus.d_mem_we = is_st;
                // A ready on the would-be timeout cycle completes the access instead of trapping.
                if (bus.d_mem_ready) begin
                    if (is_st) begin
                        pc_en   = 1'b1;
                        state_d = FETCH;
                    end else begin
                        state_d = WRITEBACK;
                    end
                end else if (wait_q == WAIT_W'(MEM_TIMEOUT - 1)) begin
                    state_d = ERROR;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            WRITEBACK: begin
                bus.rf_we  = 1'b1;
                bus.rf_src = is_ld;
                pc_en      = 1'b1;
                state_d    = FETCH;
            end
            ERROR: begin
                bus.illegal_instr = 1'b1;
            end
            default: begin
                state_d = ERROR;
            end
        endcase
    end

    assign bus.pc_en     = pc_en;
    assign bus.state_dbg = state_q;
    assign bus.instret   = instret_q;
endmodule

// File: tb/tb_control_unit_fsm.sv
// Directed bench for control_unit_fsm: each cycle queues the expected control word
// and compares it against the DUT outputs sampled mid-cycle.
module tb_control_unit_fsm;
    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;
    localparam logic [6:0] OP_XX = 7'b1111111;

    typedef struct packed {
        logic [2:0]  st;
        logic        we;
        logic        rfwe;
        logic [3:0]  cmd;
        logic        src;
        logic        pcsrc;
        logic        rfsrc;
        logic        pcen;
        logic        ill;
        logic [31:0] ir;
    } exp_t;

    logic        clk;
    logic        rst_n;
    exp_t        sb_q[$];
    int          checks;
    int          failures;
    logic [31:0] m_ir;

    control_unit_fsm_if #(.CNT_WIDTH(32)) bus ();

    control_unit_fsm #(.CNT_WIDTH(32), .MEM_TIMEOUT(15)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(logic [2:0] st, logic [6:0] op, logic rdy, logic [31:0] ir);
        exp_t e;
        logic ld, s, br, i;
        e    = '0;
        ld   = (op == OP_LD);
        s    = (op == OP_ST);
        br   = (op == OP_BR);
        i    = (op == OP_I);
        e.st = st;
        e.ir = ir;
        if (st == 3'd2 || st == 3'd3 || st == 3'd4) begin
            e.cmd = (ld || s) ? 4'h0 : (br ? 4'h1 : 4'h2);
            e.src = i || ld || s;
        end
        case (st)
            3'd2: if (br) begin e.pcsrc = 1'b1; e.pcen = 1'b1; end
            3'd3: begin e.we = s; e.pcen = s && rdy; end
            3'd4: begin e.rfwe = 1'b1; e.rfsrc = ld; e.pcen = 1'b1; end
            3'd7: e.ill = 1'b1;
            default: ;
        endcase
        return e;
    endfunction

    task automatic check(input string tag, input logic [2:0] st, input logic [6:0] op, input logic rdy);
        exp_t e, obs;
        sb_q.push_back(model(st, op, rdy, m_ir));
        #1;
        obs = {bus.state_dbg, bus.d_mem_we, bus.rf_we, bus.alu_cmd, bus.alu_src,
               bus.pc_src, bus.rf_src, bus.pc_en, bus.illegal_instr, bus.instret};
        e = sb_q.pop_front();
        checks++;
        assert (obs === e) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, e);
        end
        if (e.pcen && rst_n) m_ir++;
    endtask

    task automatic step(input string tag, input logic [2:0] st, input logic [6:0] op, input logic rdy);
        @(negedge clk);
        bus.opcode      = op;
        bus.d_mem_ready = rdy;
        bus.alu_flags   = 4'($urandom);
        check(tag, st, op, rdy);
    endtask

    // Leaves run=0 so the caller's first FETCH check is stable.
    task automatic pulse_reset(input string tag);
        @(negedge clk);
        rst_n   = 1'b0;
        bus.run = 1'b0;
        m_ir    = '0;
        check(tag, 3'd0, OP_R, 1'b0);
        step({tag, "_hold"}, 3'd0, OP_R, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        m_ir            = '0;
        rst_n           = 1'b0;
        bus.run         = 1'b0;
        bus.opcode      = OP_R;
        bus.alu_flags   = '0;
        bus.d_mem_ready = 1'b0;

        step("reset0", 3'd0, OP_R, 1'b0);
        step("reset1", 3'd0, OP_R, 1'b0);

        // R-type loop: 0,1,2,4
        @(negedge clk);
        rst_n   = 1'b1;
        bus.run = 1'b1;
        check("r_f", 3'd0, OP_R, 1'b0);
        step("r_d", 3'd1, OP_R, 1'b0);
        step("r_e", 3'd2, OP_R, 1'b0);
        step("r_w", 3'd4, OP_R, 1'b0);
        for (int k = 0; k < 2; k++) begin
            step("r_f", 3'd0, OP_R, 1'b0);
            step("r_d", 3'd1, OP_R, 1'b0);
            step("r_e", 3'd2, OP_R, 1'b0);
            step("r_w", 3'd4, OP_R, 1'b0);
        end

        // Load with two wait cycles
        step("ld_f", 3'd0, OP_LD, 1'b0);
        step("ld_d", 3'd1, OP_LD, 1'b0);
        step("ld_e", 3'd2, OP_LD, 1'b0);
        step("ld_m0", 3'd3, OP_LD, 1'b0);
        step("ld_m1", 3'd3, OP_LD, 1'b0);
        step("ld_m2", 3'd3, OP_LD, 1'b1);
        step("ld_w", 3'd4, OP_LD, 1'b0);

        // Store, ready on first MEMORY cycle
        step("st_f", 3'd0, OP_ST, 1'b0);
        step("st_d", 3'd1, OP_ST, 1'b0);
        step("st_e", 3'd2, OP_ST, 1'b0);
        step("st_m", 3'd3, OP_ST, 1'b1);

        // I-type then two branches
        step("i_f", 3'd0, OP_I, 1'b0);
        step("i_d", 3'd1, OP_I, 1'b0);
        step("i_e", 3'd2, OP_I, 1'b0);
        step("i_w", 3'd4, OP_I, 1'b0);
        for (int k = 0; k < 2; k++) begin
            step("br_f", 3'd0, OP_BR, 1'b0);
            step("br_d", 3'd1, OP_BR, 1'b0);
            step("br_e", 3'd2, OP_BR, 1'b0);
        end

        // run is only sampled in FETCH
        bus.run = 1'b0;
        step("run_hold0", 3'd0, OP_R, 1'b0);
        step("run_hold1", 3'd0, OP_R, 1'b0);
        bus.run = 1'b1;
        step("run_d", 3'd1, OP_R, 1'b0);
        bus.run = 1'b0;
        step("run_e", 3'd2, OP_R, 1'b0);
        step("run_w", 3'd4, OP_R, 1'b0);
        step("run_f", 3'd0, OP_R, 1'b0);
        step("run_f2", 3'd0, OP_R, 1'b0);
        bus.run = 1'b1;

        // Load timeout: 15 non-ready MEMORY cycles, then ERROR
        step("to_d", 3'd1, OP_LD, 1'b0);
        step("to_e", 3'd2, OP_LD, 1'b0);
        for (int k = 0; k < 15; k++) step("to_m", 3'd3, OP_LD, 1'b0);
        step("to_err0", 3'd7, OP_LD, 1'b0);
        step("to_err1", 3'd7, OP_LD, 1'b1);

        // Ready on the 15th MEMORY cycle wins over the timeout
        pulse_reset("to_rst");
        step("rw_f0", 3'd0, OP_LD, 1'b0);
        bus.run = 1'b1;
        step("rw_d", 3'd1, OP_LD, 1'b0);
        step("rw_e", 3'd2, OP_LD, 1'b0);
        for (int k = 0; k < 14; k++) step("rw_m", 3'd3, OP_LD, 1'b0);
        step("rw_m15", 3'd3, OP_LD, 1'b1);
        step("rw_w", 3'd4, OP_LD, 1'b0);

        // Reset in the middle of a store's MEMORY wait
        step("mr_f", 3'd0, OP_ST, 1'b0);
        step("mr_d", 3'd1, OP_ST, 1'b0);
        step("mr_e", 3'd2, OP_ST, 1'b0);
        step("mr_m0", 3'd3, OP_ST, 1'b0);
        @(negedge clk);
        check("mr_m1", 3'd3, OP_ST, 1'b0);
        rst_n   = 1'b0;
        bus.run = 1'b0;
        m_ir    = '0;
        check("mr_async", 3'd0, OP_ST, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step("mr_f0", 3'd0, OP_BR, 1'b0);
        bus.run = 1'b1;
        step("mr_bd", 3'd1, OP_BR, 1'b0);
        step("mr_be", 3'd2, OP_BR, 1'b0);

        // Illegal opcode: sticky ERROR until reset
        step("il_f", 3'd0, OP_XX, 1'b0);
        step("il_d", 3'd1, OP_XX, 1'b0);
        for (int k = 0; k < 50; k++) step("il_err", 3'd7, OP_R, 1'(k[0]));
        pulse_reset("il_rst");
        step("il_after", 3'd0, OP_R, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
